// File: rtl/wd_pkg.sv
// Shared watchdog definitions: generator state encoding, detector fault codes, parameter check.
// No logic of its own; imported by the service generator and its window timer.
package wd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } wd_state_e;

  // Fault codes reported on FLSTAT by the fail detector.
  localparam logic [2:0] FL_OVERRIDE    = 3'b000;
  localparam logic [2:0] FL_SRVC_CLOSED = 3'b001;
  localparam logic [2:0] FL_DOUBLE_SRVC = 3'b010;
  localparam logic [2:0] FL_NO_SRVC     = 3'b011;
  localparam logic [2:0] FL_NONE        = 3'b111;

  function automatic bit wd_params_ok(input int period, input int open,
                                      input int delay, input int width);
    return (period >= 4) && (open < period) && (delay >= 1) &&
           (width >= 1) && (delay + width < open);
  endfunction

endpackage

// File: rtl/wd_service_generator_if.sv
// Service generator <-> detector/application signal bundle; all outputs registered, no backpressure.
interface wd_service_generator_if;
  logic        ENABLE;
  logic        HBEAT;
  logic        WDFAIL;
  logic [2:0]  FLSTAT;
  logic        SWSTAT;
  logic        WDSRVC;
  logic        MISSED;
  logic        HALTED;
  logic [2:0]  LAST_FAULT;
  logic [15:0] SRVC_CNT;

  modport master (
    output ENABLE, HBEAT, WDFAIL, FLSTAT,
    input  SWSTAT, WDSRVC, MISSED, HALTED, LAST_FAULT, SRVC_CNT
  );

  modport slave (
    input  ENABLE, HBEAT, WDFAIL, FLSTAT,
    output SWSTAT, WDSRVC, MISSED, HALTED, LAST_FAULT, SRVC_CNT
  );
endinterface

// File: rtl/wd_window_timer.sv
// Window phase counter; decodes the *next* phase so the parent can register its outputs.
// Phase advances only while the parent stays in RUN; entering RUN loads phase 0.
module wd_window_timer
  import wd_pkg::*;
#(
  parameter int WIN_PERIOD = 16,
  parameter int WIN_OPEN   = 8,
  parameter int SRVC_DELAY = 2,
  parameter int SRVC_WIDTH = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic cnt_en,
  input  logic active,
  output logic win_end,
  output logic nxt_win_start,
  output logic nxt_open,
  output logic nxt_srvc_start,
  output logic nxt_srvc_on,
  output logic nxt_last_open
);

  localparam int PW = $clog2(WIN_PERIOD);
  localparam logic [PW-1:0] LAST_PH   = PW'(WIN_PERIOD - 1);
  localparam logic [PW-1:0] OPEN_PH   = PW'(WIN_OPEN);
  localparam logic [PW-1:0] SRVC_PH   = PW'(SRVC_DELAY);
  localparam logic [PW-1:0] SRVC_END  = PW'(SRVC_DELAY + SRVC_WIDTH - 1);
  localparam logic [PW-1:0] CLOSE_PH  = PW'(WIN_OPEN - 1);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = '0;
    if (cnt_en) begin
      phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign win_end        = (phase_q == LAST_PH);
  assign nxt_win_start  = active && (phase_d == '0);
  assign nxt_open       = active && (phase_d < OPEN_PH);
  assign nxt_srvc_start = active && (phase_d == SRVC_PH);
  assign nxt_srvc_on    = active && (phase_d >= SRVC_PH) && (phase_d <= SRVC_END);
  assign nxt_last_open  = active && (phase_d == CLOSE_PH);

endmodule

// File: rtl/wd_service_generator.sv
// Watchdog service generator: opens SWSTAT windows, issues one WDSRVC per window when a heartbeat is pending.
// Outputs registered (1-cycle from sampled inputs); a detector fault latches the code and halts until RST.
module wd_service_generator
  import wd_pkg::*;
#(
  parameter int WIN_PERIOD = 16,
  parameter int WIN_OPEN   = 8,
  parameter int SRVC_DELAY = 2,
  parameter int SRVC_WIDTH = 2
) (
  input logic                   CLK,
  input logic                   RST,
  wd_service_generator_if.slave bus
);

  if (!wd_params_ok(WIN_PERIOD, WIN_OPEN, SRVC_DELAY, SRVC_WIDTH)) begin : g_bad_params
    $error("wd_service_generator: illegal window/service parameters");
  end

  wd_state_e   state_q, state_d;
  logic        armed_q, armed_d;
  logic        srvc_done_q, srvc_done_d;
  logic        swstat_q, swstat_d;
  logic        wdsrvc_q, wdsrvc_d;
  logic        missed_q, missed_d;
  logic        halted_q, halted_d;
  logic [2:0]  last_fault_q, last_fault_d;
  logic [15:0] srvc_cnt_q, srvc_cnt_d;

  logic cnt_en, active, srvc_start;
  logic win_end, nxt_win_start, nxt_open, nxt_srvc_start, nxt_srvc_on, nxt_last_open;

  assign active = (state_d == ST_RUN);
  assign cnt_en = (state_q == ST_RUN) && active;

  wd_window_timer #(
    .WIN_PERIOD (WIN_PERIOD),
    .WIN_OPEN   (WIN_OPEN),
    .SRVC_DELAY (SRVC_DELAY),
    .SRVC_WIDTH (SRVC_WIDTH)
  ) u_timer (
    .CLK            (CLK),
    .RST            (RST),
    .cnt_en         (cnt_en),
    .active         (active),
    .win_end        (win_end),
    .nxt_win_start  (nxt_win_start),
    .nxt_open       (nxt_open),
    .nxt_srvc_start (nxt_srvc_start),
    .nxt_srvc_on    (nxt_srvc_on),
    .nxt_last_open  (nxt_last_open)
  );

  // WDFAIL wins over ENABLE; RUN only looks at ENABLE on the last phase of a window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.WDFAIL)      state_d = ST_HALT;
        else if (bus.ENABLE) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.WDFAIL)                   state_d = ST_HALT;
        else if (win_end && !bus.ENABLE)  state_d = ST_IDLE;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // A pulse is committed one cycle ahead so WDSRVC is high exactly on the service phases.
  assign srvc_start = nxt_srvc_start && armed_q;

  always_comb begin
    armed_d      = armed_q;
    srvc_done_d  = srvc_done_q;
    srvc_cnt_d   = srvc_cnt_q;
    last_fault_d = last_fault_q;
    swstat_d     = nxt_open;
    wdsrvc_d     = srvc_start || (wdsrvc_q && nxt_srvc_on);
    missed_d     = nxt_last_open && !srvc_done_q;
    halted_d     = (state_d == ST_HALT);

    if (srvc_start) armed_d = 1'b0;
    // A heartbeat coinciding with a service start re-arms for the following window.
    if (bus.HBEAT && state_q != ST_HALT) armed_d = 1'b1;

    if (!active)            srvc_done_d = 1'b0;
    else if (srvc_start)    srvc_done_d = 1'b1;
    else if (nxt_win_start) srvc_done_d = 1'b0;

    if (srvc_start && srvc_cnt_q != 16'hFFFF) srvc_cnt_d = srvc_cnt_q + 16'd1;

    if (state_q != ST_HALT && bus.WDFAIL) last_fault_d = bus.FLSTAT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      srvc_done_q  <= 1'b0;
      swstat_q     <= 1'b0;
      wdsrvc_q     <= 1'b0;
      missed_q     <= 1'b0;
      halted_q     <= 1'b0;
      last_fault_q <= FL_NONE;
      srvc_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      srvc_done_q  <= srvc_done_d;
      swstat_q     <= swstat_d;
      wdsrvc_q     <= wdsrvc_d;
      missed_q     <= missed_d;
      halted_q     <= halted_d;
      last_fault_q <= last_fault_d;
      srvc_cnt_q   <= srvc_cnt_d;
    end
  end

  assign bus.SWSTAT     = swstat_q;
  assign bus.WDSRVC     = wdsrvc_q;
  assign bus.MISSED     = missed_q;
  assign bus.HALTED     = halted_q;
  assign bus.LAST_FAULT = last_fault_q;
  assign bus.SRVC_CNT   = srvc_cnt_q;

endmodule
